// File: rtl/gpio_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_pattern_sequencer
//  Description : Autonomous Avalon-MM master. It replays a CPU-programmed table
//                of 2-bit values into a GPIO PIO slave at a programmable
//                interval. The CPU configures it through an Avalon-MM CSR slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_pattern_sequencer #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    // CSR slave
    input  logic [2:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    // PIO master
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    // Status
    output logic        busy,
    output logic        irq
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PAT_W = 2 * MAX_LEN;

    localparam logic [2:0] c_addr_ctrl     = 3'd0;
    localparam logic [2:0] c_addr_status   = 3'd1;
    localparam logic [2:0] c_addr_config   = 3'd2;
    localparam logic [2:0] c_addr_interval = 3'd3;
    localparam logic [2:0] c_addr_pattern  = 3'd4;

    localparam logic [3:0]       c_len_clip = 4'(MAX_LEN - 1);
    localparam logic [IDX_W-1:0] c_idx_max  = IDX_W'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Configuration registers
    logic             r_loop;
    logic             r_irq_en;
    logic [3:0]       r_len;
    logic [CNT_W-1:0] r_interval;
    logic [PAT_W-1:0] r_pattern;

    // Sequencer state
    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_stop_pending;

    // Decoded CSR activity
    logic             w_csr_wr;
    logic             w_busy;
    logic             w_cfg_wr_ok;
    logic             w_start;
    logic             w_stop;
    logic             w_done_clr;
    logic [IDX_W-1:0] w_last;
    logic [1:0]       w_entry;
    logic [CNT_W-1:0] w_reload;
    logic             w_unused_ok;

    assign w_csr_wr    = s_chipselect & ~s_write_n;
    assign w_busy      = (r_state != ST_IDLE);
    assign w_cfg_wr_ok = w_csr_wr & ~w_busy;

    // STOP has priority over START when both bits arrive in one write.
    assign w_start    = w_csr_wr && (s_address == c_addr_ctrl) && s_writedata[0] && !s_writedata[1];
    assign w_stop     = w_csr_wr && (s_address == c_addr_ctrl) && s_writedata[1];
    assign w_done_clr = w_csr_wr && (s_address == c_addr_status) && s_writedata[1];

    // Last table index in use: LEN, clipped to the table depth.
    assign w_last = (r_len >= c_len_clip) ? c_idx_max : r_len[IDX_W-1:0];

    // Table entry addressed by the current index.
    assign w_entry = r_pattern[{r_idx, 1'b0} +: 2];

    // An interval of zero behaves as an interval of one.
    assign w_reload = (r_interval == '0) ? '0 : (r_interval - CNT_W'(1));

    assign m_address = 2'b00;
    assign busy      = w_busy;
    assign irq       = r_done & r_irq_en;

    // Only part of the write bus maps onto register bits.
    assign w_unused_ok = &{1'b0, s_writedata};

    // Configuration registers, frozen while a sequence runs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_loop     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_len      <= 4'd0;
            r_interval <= '0;
            r_pattern  <= '0;
        end else if (w_cfg_wr_ok) begin
            case (s_address)
                c_addr_config: begin
                    r_loop   <= s_writedata[0];
                    r_irq_en <= s_writedata[1];
                    r_len    <= s_writedata[11:8];
                end
                c_addr_interval: r_interval <= s_writedata[CNT_W-1:0];
                c_addr_pattern:  r_pattern  <= s_writedata[PAT_W-1:0];
                default: ;
            endcase
        end
    end

    // Sequencer FSM with registered master outputs, DONE and STOP tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_done         <= 1'b0;
            r_stop_pending <= 1'b0;
            m_chipselect   <= 1'b0;
            m_write_n      <= 1'b1;
            m_writedata    <= 32'd0;
        end else begin
            // A clear and a set on the same edge resolve to set (set is later).
            if (w_done_clr) begin
                r_done <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_stop_pending <= 1'b0;
                    if (w_start) begin
                        r_idx        <= '0;
                        r_done       <= 1'b0;
                        r_state      <= ST_WRITE;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_writedata  <= {30'd0, r_pattern[1:0]};
                    end
                end
                ST_WRITE: begin
                    if (w_stop) begin
                        r_stop_pending <= 1'b1;
                    end
                    // The in-flight write always completes, STOP or not.
                    if (!m_waitrequest) begin
                        m_chipselect <= 1'b0;
                        m_write_n    <= 1'b1;
                        if ((r_idx == w_last) && !r_loop) begin
                            r_done         <= 1'b1;
                            r_state        <= ST_IDLE;
                            r_stop_pending <= 1'b0;
                        end else if (r_stop_pending) begin
                            r_state        <= ST_IDLE;
                            r_stop_pending <= 1'b0;
                        end else begin
                            r_idx   <= (r_idx == w_last) ? '0 : (r_idx + IDX_W'(1));
                            r_cnt   <= w_reload;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_stop) begin
                        r_stop_pending <= 1'b1;
                    end
                    if (r_stop_pending) begin
                        r_state        <= ST_IDLE;
                        r_stop_pending <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state      <= ST_WRITE;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_writedata  <= {30'd0, w_entry};
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    m_chipselect <= 1'b0;
                    m_write_n    <= 1'b1;
                end
            endcase
        end
    end

    // Zero-wait-state CSR read mux.
    always_comb begin
        s_readdata = 32'd0;
        case (s_address)
            c_addr_status:   s_readdata = {30'd0, r_done, w_busy};
            c_addr_config:   s_readdata = {20'd0, r_len, 6'd0, r_irq_en, r_loop};
            c_addr_interval: s_readdata = 32'(r_interval);
            c_addr_pattern:  s_readdata = 32'(r_pattern);
            default:         s_readdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_pattern_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_gpio_pattern_sequencer
//  Description : Scoreboard bench for gpio_pattern_sequencer. Expected PIO
//                writes (value and spacing) are queued as each sequence starts
//                and are popped as the master's writes are accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  s_address = 3'd0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = 32'd0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;
    logic        busy;
    logic        irq;

    gpio_pattern_sequencer #(.MAX_LEN(8), .CNT_W(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_address     (s_address),
        .s_chipselect  (s_chipselect),
        .s_write_n     (s_write_n),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .busy          (busy),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          gap;   // cycles since previous accepted write, -1 = unchecked
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    int          stall_cycles = 0;
    logic [31:0] last_data = 32'd0;
    logic [31:0] rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        tick();
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        s_address    = a;
        s_chipselect = 1'b1;
        s_write_n    = 1'b1;
        #1;
        d            = s_readdata;
        s_chipselect = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input int gap);
        exp_t e;
        e.data = d;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check_eq("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_drained(input int limit);
        int n = 0;
        while (sb.size() > 0 && n < limit) begin
            tick();
            n++;
        end
        check_eq("drain", sb.size(), 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: a write request seen at the falling edge with waitrequest low
    // is accepted on the following rising edge.
    initial forever begin
        @(negedge clk);
        if (reset_n && m_chipselect && !m_write_n) begin
            if (m_waitrequest) begin
                stall_cycles++;
                if (sb.size() > 0) check_eq("stall_data", m_writedata, sb[0].data);
            end else if (sb.size() == 0) begin
                check_eq("unexpected_write", sb.size(), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check_eq("pio_addr", 32'(m_address), 32'd0);
                check_eq("pio_data", m_writedata, mon_e.data);
                if (mon_e.gap >= 0) check_eq("pio_gap", cyc - last_cyc, mon_e.gap);
                last_cyc  = cyc;
                last_data = m_writedata;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs", 32'(m_chipselect), 32'd0);
        check_eq("rst_wn", 32'(m_write_n), 32'd1);
        check_eq("rst_wdata", m_writedata, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            csr_read(3'(a), rd);
            check_eq("rst_csr", rd, 32'd0);
        end

        // One-shot sequence 0,1,2,3 at interval 4 with IRQ enabled
        csr_write(3'd4, 32'h0000_00E4);
        csr_write(3'd2, 32'h0000_0302);
        csr_write(3'd3, 32'd4);
        csr_read(3'd2, rd);
        check_eq("config_rb", rd, 32'h0000_0302);
        push(0, -1); push(1, 5); push(2, 5); push(3, 5);
        csr_write(3'd0, 32'd1);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        wait_idle(100);
        wait_drained(10);
        csr_read(3'd1, rd);
        check_eq("status_done", rd, 32'd2);
        check_eq("irq_done", 32'(irq), 32'd1);
        check_eq("out_port_final", last_data, 32'd3);
        csr_write(3'd1, 32'd2);
        csr_read(3'd1, rd);
        check_eq("status_cleared", rd, 32'd0);
        check_eq("irq_cleared", 32'(irq), 32'd0);

        // Looping sequence with wrap, stopped during WAIT
        csr_write(3'd2, 32'h0000_0301);
        push(0, -1); push(1, 5); push(2, 5); push(3, 5); push(0, 5); push(1, 5);
        csr_write(3'd0, 32'd1);
        wait_drained(100);
        tick();
        csr_write(3'd0, 32'd2);
        tick();
        check_eq("stop_busy", 32'(busy), 32'd0);
        csr_read(3'd1, rd);
        check_eq("stop_status", rd, 32'd0);
        repeat (20) tick();

        // Three stalled cycles on the second write
        csr_write(3'd2, 32'h0000_0300);
        push(0, -1); push(1, 8); push(2, 5); push(3, 5);
        stall_cycles = 0;
        csr_write(3'd0, 32'd1);
        for (int n = 0; n < 50 && !(m_chipselect && m_writedata == 32'd1); n++) tick();
        m_waitrequest = 1'b1;
        repeat (3) tick();
        m_waitrequest = 1'b0;
        wait_idle(100);
        wait_drained(10);
        check_eq("stall_cycles", stall_cycles, 32'd3);
        csr_read(3'd1, rd);
        check_eq("stall_status", rd, 32'd2);

        // Interval 0, two entries: writes exactly two cycles apart
        csr_write(3'd4, 32'h0000_0002);
        csr_write(3'd2, 32'h0000_0100);
        csr_write(3'd3, 32'd0);
        push(2, -1); push(0, 2);
        csr_write(3'd0, 32'd1);
        wait_idle(50);
        wait_drained(10);
        csr_read(3'd1, rd);
        check_eq("int0_status", rd, 32'd2);
        check_eq("int0_irq_masked", 32'(irq), 32'd0);

        // Table, config and START writes are ignored while busy
        csr_write(3'd4, 32'h0000_00E4);
        csr_write(3'd2, 32'h0000_0302);
        csr_write(3'd3, 32'd4);
        push(0, -1); push(1, 5); push(2, 5); push(3, 5);
        csr_write(3'd0, 32'd1);
        tick();
        csr_write(3'd4, 32'h0000_00FF);
        csr_write(3'd0, 32'd1);
        csr_write(3'd2, 32'h0000_0301);
        wait_idle(100);
        wait_drained(10);
        csr_read(3'd4, rd);
        check_eq("pattern_kept", rd, 32'h0000_00E4);
        csr_read(3'd2, rd);
        check_eq("config_kept", rd, 32'h0000_0302);

        // START together with STOP while idle starts nothing
        csr_write(3'd0, 32'd3);
        check_eq("startstop_busy", 32'(busy), 32'd0);
        csr_read(3'd1, rd);
        check_eq("startstop_status", rd, 32'd2);

        // Asynchronous reset during a stalled write
        m_waitrequest = 1'b1;
        csr_write(3'd0, 32'd1);
        check_eq("pre_reset_cs", 32'(m_chipselect), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("areset_cs", 32'(m_chipselect), 32'd0);
        check_eq("areset_wn", 32'(m_write_n), 32'd1);
        check_eq("areset_busy", 32'(busy), 32'd0);
        check_eq("areset_wdata", m_writedata, 32'd0);
        m_waitrequest = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            csr_read(3'(a), rd);
            check_eq("post_reset_csr", rd, 32'd0);
        end
        check_eq("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
